// File: rtl/logcap_pkg.sv
// Shared definitions for the trigger capture controller.
//   cap_state_e       : capture FSM state encoding (visible on the state port)
//   PKT_SAMPLE_LSB    : bit offset of the sample field inside a trace packet
//   pkt_run_lsb()     : bit offset of the run-length field (above the sample)
//   pkt_width()       : total packet width
package logcap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_DONE    = 3'd5
  } cap_state_e;

  localparam int PKT_SAMPLE_LSB = 0;

  function automatic int pkt_run_lsb(input int sample_width);
    return PKT_SAMPLE_LSB + sample_width;
  endfunction

  function automatic int pkt_width(input int sample_width, input int run_width);
    return sample_width + run_width;
  endfunction

endpackage

// File: rtl/trigger_match.sv
// Trigger evaluation: pattern compare, single-channel edge detect against the
// previous captured sample, and an occurrence counter that fires on the
// n-th match seen while counting is enabled.
//   clk, reset_n      : clock, async active-low reset
//   i_clear           : restart (clears edge history and match counter)
//   i_update          : a captured sample is present (advances edge history)
//   i_count_en        : captured sample while armed (matches are counted)
//   i_sample          : current sample
//   i_pattern/i_care_mask, i_edge_ch/i_edge_rise, i_pattern_en/i_edge_en,
//   i_trig_count      : trigger configuration
//   o_trig            : this sample is the firing match
module trigger_match #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_clear,
  input  logic                            i_update,
  input  logic                            i_count_en,
  input  logic [SAMPLE_WIDTH-1:0]         i_sample,
  input  logic [SAMPLE_WIDTH-1:0]         i_pattern,
  input  logic [SAMPLE_WIDTH-1:0]         i_care_mask,
  input  logic [$clog2(SAMPLE_WIDTH)-1:0] i_edge_ch,
  input  logic                            i_edge_rise,
  input  logic                            i_pattern_en,
  input  logic                            i_edge_en,
  input  logic [7:0]                      i_trig_count,
  output logic                            o_trig
);

  logic       r_prev_bit;
  logic       r_prev_valid;
  logic [7:0] r_match_cnt;

  logic       w_pat_hit;
  logic       w_cur_bit;
  logic       w_edge_hit;
  logic       w_match;
  logic [7:0] w_target;

  assign w_pat_hit = ((i_sample ^ i_pattern) & i_care_mask) == '0;
  assign w_cur_bit = i_sample[i_edge_ch];

  // No edge can be seen until one sample has been captured since the restart.
  assign w_edge_hit = r_prev_valid &&
                      (i_edge_rise ? (!r_prev_bit &&  w_cur_bit)
                                   : ( r_prev_bit && !w_cur_bit));

  // A disabled term is transparent; with both disabled every sample matches.
  assign w_match  = (!i_pattern_en || w_pat_hit) && (!i_edge_en || w_edge_hit);

  // A count of zero behaves as one (fire on the first match).
  assign w_target = (i_trig_count == 8'd0) ? 8'd1 : i_trig_count;

  assign o_trig   = i_count_en && w_match && (r_match_cnt == (w_target - 8'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_bit   <= 1'b0;
      r_prev_valid <= 1'b0;
      r_match_cnt  <= 8'd0;
    end else if (i_clear) begin
      r_prev_bit   <= 1'b0;
      r_prev_valid <= 1'b0;
      r_match_cnt  <= 8'd0;
    end else begin
      if (i_update) begin
        r_prev_bit   <= w_cur_bit;
        r_prev_valid <= 1'b1;
      end
      if (i_count_en && w_match) begin
        r_match_cnt <= r_match_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/trigger_capture_ctrl.sv
// Logic-analyser capture controller: samples are packed into {run_len, sample}
// trace packets (optionally run-length compressed), written to a circular
// trace memory with a pre-trigger window and a post-trigger window.
//   clk, reset_n                 : clock, async active-low reset
//   sample_in, sample_valid      : sample stream and its qualifier
//   cfg_*                        : trigger / window / compression configuration
//   start, abort                 : single-cycle commands
//   wr_en, wr_addr, wr_data      : trace memory write port
//   trig_addr                    : address of the trigger packet
//   state, done, cfg_error       : status
//
// state   | meaning
// IDLE    | waiting for start
// PREFILL | filling the pre-trigger window, triggers not evaluated
// ARMED   | circular capture, counting matches
// POST    | capturing the post-trigger window
// FLUSH   | emitting the still-open run, one cycle
// DONE    | capture complete, done asserted
module trigger_capture_ctrl
  import logcap_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int RUN_WIDTH    = 16,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [SAMPLE_WIDTH-1:0]              sample_in,
  input  logic                                 sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]              cfg_pattern,
  input  logic [SAMPLE_WIDTH-1:0]              cfg_care_mask,
  input  logic [$clog2(SAMPLE_WIDTH)-1:0]      cfg_edge_ch,
  input  logic                                 cfg_edge_rise,
  input  logic                                 cfg_pattern_en,
  input  logic                                 cfg_edge_en,
  input  logic                                 cfg_rle_en,
  input  logic [7:0]                           cfg_trig_count,
  input  logic [ADDR_WIDTH-1:0]                cfg_pre_count,
  input  logic [ADDR_WIDTH:0]                  cfg_post_count,
  input  logic                                 start,
  input  logic                                 abort,
  output logic                                 wr_en,
  output logic [ADDR_WIDTH-1:0]                wr_addr,
  output logic [RUN_WIDTH+SAMPLE_WIDTH-1:0]    wr_data,
  output logic [ADDR_WIDTH-1:0]                trig_addr,
  output logic [2:0]                           state,
  output logic                                 done,
  output logic                                 cfg_error
);

  localparam int PktW   = pkt_width(SAMPLE_WIDTH, RUN_WIDTH);
  localparam int RunLsb = pkt_run_lsb(SAMPLE_WIDTH);

  localparam logic [RUN_WIDTH-1:0]  RunOne = RUN_WIDTH'(1);
  localparam logic [RUN_WIDTH-1:0]  RunMax = '1;
  localparam logic [ADDR_WIDTH:0]   CntOne = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH+1:0] Depth  = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;

  cap_state_e                r_state;
  logic [ADDR_WIDTH-1:0]     r_ptr;
  logic [ADDR_WIDTH:0]       r_cnt;
  logic                      r_wr_en;
  logic [ADDR_WIDTH-1:0]     r_wr_addr;
  logic [PktW-1:0]           r_wr_data;
  logic [ADDR_WIDTH-1:0]     r_trig_addr;
  logic                      r_cfg_error;
  logic                      r_run_open;
  logic [SAMPLE_WIDTH-1:0]   r_run_sample;
  logic [RUN_WIDTH-1:0]      r_run_len;

  cap_state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0]     w_ptr_nxt;
  logic [ADDR_WIDTH:0]       w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]     w_trig_addr_nxt;
  logic                      w_cfg_error_nxt;
  logic                      w_run_open_nxt;
  logic [SAMPLE_WIDTH-1:0]   w_run_sample_nxt;
  logic [RUN_WIDTH-1:0]      w_run_len_nxt;
  logic                      w_emit;
  logic [PktW-1:0]           w_emit_data;
  logic                      w_start_ok;
  logic                      w_extend;

  logic                      w_capturing;
  logic                      w_trig;
  logic [ADDR_WIDTH:0]       w_post_eff;
  logic [ADDR_WIDTH+1:0]     w_need;
  logic                      w_cfg_fits;

  assign w_capturing = (r_state == ST_PREFILL) || (r_state == ST_ARMED) ||
                       (r_state == ST_POST);

  assign w_post_eff  = (cfg_post_count == '0) ? CntOne : cfg_post_count;
  assign w_need      = {2'b00, cfg_pre_count} + {1'b0, w_post_eff};
  assign w_cfg_fits  = (w_need <= Depth);

  trigger_match #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_trigger_match (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (w_start_ok),
    .i_update     (w_capturing && sample_valid && !abort),
    .i_count_en   ((r_state == ST_ARMED) && sample_valid && !abort),
    .i_sample     (sample_in),
    .i_pattern    (cfg_pattern),
    .i_care_mask  (cfg_care_mask),
    .i_edge_ch    (cfg_edge_ch),
    .i_edge_rise  (cfg_edge_rise),
    .i_pattern_en (cfg_pattern_en),
    .i_edge_en    (cfg_edge_en),
    .i_trig_count (cfg_trig_count),
    .o_trig       (w_trig)
  );

  // The trigger sample always opens its own run, so it never extends one.
  assign w_extend = r_run_open && (sample_in == r_run_sample) &&
                    (r_run_len != RunMax) && !w_trig;

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_cnt_nxt        = r_cnt;
    w_trig_addr_nxt  = r_trig_addr;
    w_cfg_error_nxt  = r_cfg_error;
    w_run_open_nxt   = r_run_open;
    w_run_sample_nxt = r_run_sample;
    w_run_len_nxt    = r_run_len;
    w_emit           = 1'b0;
    w_emit_data      = '0;
    w_start_ok       = 1'b0;

    if (abort) begin
      w_state_nxt    = ST_IDLE;
      w_run_open_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (w_cfg_fits) begin
              w_start_ok       = 1'b1;
              w_cfg_error_nxt  = 1'b0;
              w_ptr_nxt        = '0;
              w_run_open_nxt   = 1'b0;
              w_run_sample_nxt = '0;
              w_run_len_nxt    = '0;
              w_cnt_nxt        = {1'b0, cfg_pre_count};
              w_state_nxt      = (cfg_pre_count == '0) ? ST_ARMED : ST_PREFILL;
            end else begin
              w_cfg_error_nxt = 1'b1;
            end
          end
        end

        ST_PREFILL, ST_ARMED, ST_POST: begin
          if (sample_valid) begin
            if (!cfg_rle_en) begin
              // Uncompressed: every sample is a complete packet.
              w_emit = 1'b1;
              w_emit_data[RunLsb +: RUN_WIDTH]               = RunOne;
              w_emit_data[PKT_SAMPLE_LSB +: SAMPLE_WIDTH]    = sample_in;
              case (r_state)
                ST_PREFILL: begin
                  w_cnt_nxt = r_cnt - 1'b1;
                  if (r_cnt == CntOne) w_state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                  if (w_trig) begin
                    w_trig_addr_nxt = r_ptr;
                    w_cnt_nxt       = w_post_eff - 1'b1;
                    w_state_nxt     = (w_post_eff == CntOne) ? ST_FLUSH : ST_POST;
                  end
                end
                default: begin
                  w_cnt_nxt = r_cnt - 1'b1;
                  if (r_cnt == CntOne) w_state_nxt = ST_FLUSH;
                end
              endcase
            end else if (w_extend) begin
              w_run_len_nxt = r_run_len + 1'b1;
            end else if ((r_state == ST_POST) && r_run_open && (r_cnt == '0)) begin
              // Window full: the open run is the last packet, this sample is
              // not part of the capture.
              w_state_nxt = ST_FLUSH;
            end else begin
              // Run boundary: emit the open run, start a new one here.
              if (r_run_open) begin
                w_emit = 1'b1;
                w_emit_data[RunLsb +: RUN_WIDTH]            = r_run_len;
                w_emit_data[PKT_SAMPLE_LSB +: SAMPLE_WIDTH] = r_run_sample;
              end
              w_run_open_nxt   = 1'b1;
              w_run_sample_nxt = sample_in;
              w_run_len_nxt    = RunOne;
              case (r_state)
                ST_PREFILL: begin
                  if (r_run_open) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == CntOne) w_state_nxt = ST_ARMED;
                  end
                end
                ST_ARMED: begin
                  if (w_trig) begin
                    // Trigger run lands after the run being emitted now.
                    w_trig_addr_nxt = r_run_open ? (r_ptr + 1'b1) : r_ptr;
                    w_cnt_nxt       = w_post_eff - 1'b1;
                    w_state_nxt     = ST_POST;
                  end
                end
                default: begin
                  w_cnt_nxt = r_cnt - 1'b1;
                end
              endcase
            end
          end
        end

        ST_FLUSH: begin
          if (r_run_open) begin
            w_emit = 1'b1;
            w_emit_data[RunLsb +: RUN_WIDTH]            = r_run_len;
            w_emit_data[PKT_SAMPLE_LSB +: SAMPLE_WIDTH] = r_run_sample;
          end
          w_run_open_nxt = 1'b0;
          w_state_nxt    = ST_DONE;
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    if (w_emit) w_ptr_nxt = r_ptr + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_trig_addr  <= '0;
      r_cfg_error  <= 1'b0;
      r_run_open   <= 1'b0;
      r_run_sample <= '0;
      r_run_len    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_trig_addr  <= w_trig_addr_nxt;
      r_cfg_error  <= w_cfg_error_nxt;
      r_run_open   <= w_run_open_nxt;
      r_run_sample <= w_run_sample_nxt;
      r_run_len    <= w_run_len_nxt;
      r_wr_en      <= w_emit;
      if (w_emit) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_emit_data;
      end else if (w_start_ok) begin
        r_wr_addr <= '0;
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign trig_addr = r_trig_addr;
  assign state     = r_state;
  assign done      = (r_state == ST_DONE);
  assign cfg_error = r_cfg_error;

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
module tb_trigger_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [15:0] cfg_pattern = '0;
  logic [15:0] cfg_care_mask = '0;
  logic [3:0]  cfg_edge_ch = '0;
  logic        cfg_edge_rise = 1'b1;
  logic        cfg_pattern_en = 1'b0;
  logic        cfg_edge_en = 1'b0;
  logic        cfg_rle_en = 1'b0;
  logic [7:0]  cfg_trig_count = 8'd1;
  logic [9:0]  cfg_pre_count = '0;
  logic [10:0] cfg_post_count = 11'd1;
  logic        start = 1'b0;
  logic        abort = 1'b0;

  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  trig_addr;
  logic [2:0]  state;
  logic        done;
  logic        cfg_error;

  logic        wr_en4;
  logic [9:0]  wr_addr4;
  logic [19:0] wr_data4;
  logic [9:0]  trig_addr4;
  logic [2:0]  state4;
  logic        done4;
  logic        cfg_error4;

  trigger_capture_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .cfg_pattern(cfg_pattern), .cfg_care_mask(cfg_care_mask), .cfg_edge_ch(cfg_edge_ch),
    .cfg_edge_rise(cfg_edge_rise), .cfg_pattern_en(cfg_pattern_en), .cfg_edge_en(cfg_edge_en),
    .cfg_rle_en(cfg_rle_en), .cfg_trig_count(cfg_trig_count), .cfg_pre_count(cfg_pre_count),
    .cfg_post_count(cfg_post_count), .start(start), .abort(abort), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .trig_addr(trig_addr), .state(state),
    .done(done), .cfg_error(cfg_error)
  );

  trigger_capture_ctrl #(.RUN_WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .cfg_pattern(cfg_pattern), .cfg_care_mask(cfg_care_mask), .cfg_edge_ch(cfg_edge_ch),
    .cfg_edge_rise(cfg_edge_rise), .cfg_pattern_en(cfg_pattern_en), .cfg_edge_en(cfg_edge_en),
    .cfg_rle_en(cfg_rle_en), .cfg_trig_count(cfg_trig_count), .cfg_pre_count(cfg_pre_count),
    .cfg_post_count(cfg_post_count), .start(start), .abort(abort), .wr_en(wr_en4),
    .wr_addr(wr_addr4), .wr_data(wr_data4), .trig_addr(trig_addr4), .state(state4),
    .done(done4), .cfg_error(cfg_error4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int          wr_cnt = 0;
  logic [31:0] mem [0:1023];
  int          wr4_cnt = 0;
  logic [19:0] q4 [$];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      mem[wr_addr] = wr_data;
      wr_cnt++;
    end
    if (wr_en4 === 1'b1) begin
      q4.push_back(wr_data4);
      wr4_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic step(input logic [15:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic set_cfg(input logic pat_en, input logic edge_en, input logic rle,
                         input logic [15:0] pat, input logic [15:0] care,
                         input logic [3:0] ch, input logic rise, input logic [7:0] tcnt,
                         input logic [9:0] pre, input logic [10:0] post);
    cfg_pattern_en = pat_en;
    cfg_edge_en    = edge_en;
    cfg_rle_en     = rle;
    cfg_pattern    = pat;
    cfg_care_mask  = care;
    cfg_edge_ch    = ch;
    cfg_edge_rise  = rise;
    cfg_trig_count = tcnt;
    cfg_pre_count  = pre;
    cfg_post_count = post;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(2);
    total++;
    if ({state, wr_en, done, cfg_error} !== 6'b000000) begin
      bad++;
      $display("FAIL reset_status: got state=%0d wr_en=%b done=%b err=%b, want 0/0/0/0",
               state, wr_en, done, cfg_error);
    end
    total++;
    if ({wr_addr, trig_addr, wr_data} !== 52'd0) begin
      bad++;
      $display("FAIL reset_regs: got addr=%0d trig=%0d data=%h, want 0/0/0", wr_addr, trig_addr, wr_data);
    end
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_pattern_norle();
    int base;
    set_cfg(1'b1, 1'b0, 1'b0, 16'h00FF, 16'hFFFF, 4'd0, 1'b1, 8'd1, 10'd4, 11'd4);
    base = wr_cnt;
    do_start();
    total++;
    if (state !== 3'd1) begin bad++; $display("FAIL pat_prefill: got %0d want 1", state); end
    step(16'h0000); step(16'h0001); step(16'h0002); step(16'h0003);
    total++;
    if (state !== 3'd2) begin bad++; $display("FAIL pat_armed: got %0d want 2", state); end
    step(16'h00FF);
    total++;
    if (state !== 3'd3 || trig_addr !== 10'd4) begin
      bad++; $display("FAIL pat_trigger: got state=%0d trig=%0d want 3/4", state, trig_addr);
    end
    step(16'h0005); step(16'h0006); step(16'h0007);
    total++;
    if (state !== 3'd4) begin bad++; $display("FAIL pat_flush: got %0d want 4", state); end
    idle(1);
    total++;
    if (state !== 3'd5 || done !== 1'b1) begin
      bad++; $display("FAIL pat_done: got state=%0d done=%b want 5/1", state, done);
    end
    idle(1);
    total++;
    if (wr_cnt - base !== 8) begin bad++; $display("FAIL pat_wr_count: got %0d want 8", wr_cnt - base); end
    total++;
    if (mem[4] !== 32'h0001_00FF) begin bad++; $display("FAIL pat_trig_pkt: got %h want 000100ff", mem[4]); end
    total++;
    if (mem[0] !== 32'h0001_0000 || mem[7] !== 32'h0001_0007) begin
      bad++; $display("FAIL pat_ends: got %h/%h want 00010000/00010007", mem[0], mem[7]);
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(1'b1, 1'b0, 1'b0, 16'h00FF, 16'hFFFF, 4'd0, 1'b1, 8'd1, 10'd0, 11'd1);
    do_start();
    total++;
    if (state !== 3'd2 || done !== 1'b0 || wr_addr !== 10'd0) begin
      bad++; $display("FAIL restart: got state=%0d done=%b addr=%0d want 2/0/0", state, done, wr_addr);
    end
    step(16'h1234);
    do_start();
    total++;
    if (state !== 3'd2) begin bad++; $display("FAIL start_ignored: got %0d want 2", state); end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL abort_wins: got %0d want 0", state); end
  endtask

  task automatic test_edge();
    int base;
    logic [15:0] seq [9];
    seq = '{16'h0, 16'h8, 16'h0, 16'h8, 16'h0, 16'h8, 16'h8, 16'h0, 16'h8};
    set_cfg(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 4'd3, 1'b1, 8'd3, 10'd2, 11'd1);
    base = wr_cnt;
    do_start();
    for (int i = 0; i < 8; i++) step(seq[i]);
    total++;
    if (state !== 3'd2) begin bad++; $display("FAIL edge_early: got state %0d want 2", state); end
    step(seq[8]);
    total++;
    if (trig_addr !== 10'd8 || state !== 3'd4) begin
      bad++; $display("FAIL edge_trigger: got trig=%0d state=%0d want 8/4", trig_addr, state);
    end
    idle(2);
    total++;
    if (done !== 1'b1 || wr_cnt - base !== 9 || mem[8] !== 32'h0001_0008) begin
      bad++; $display("FAIL edge_result: got done=%b writes=%0d pkt=%h want 1/9/00010008",
                      done, wr_cnt - base, mem[8]);
    end
  endtask

  task automatic test_rle();
    int base;
    set_cfg(1'b1, 1'b0, 1'b1, 16'h000B, 16'hFFFF, 4'd0, 1'b1, 8'd1, 10'd0, 11'd2);
    base = wr_cnt;
    do_start();
    repeat (5) step(16'h000A);
    step(16'h000B);
    total++;
    if (state !== 3'd3 || trig_addr !== 10'd1) begin
      bad++; $display("FAIL rle_trigger: got state=%0d trig=%0d want 3/1", state, trig_addr);
    end
    repeat (3) step(16'h000C);
    step(16'h000D);
    total++;
    if (state !== 3'd4) begin bad++; $display("FAIL rle_flush: got %0d want 4", state); end
    idle(2);
    total++;
    if (done !== 1'b1 || wr_cnt - base !== 3) begin
      bad++; $display("FAIL rle_done: got done=%b writes=%0d want 1/3", done, wr_cnt - base);
    end
    total++;
    if (mem[0] !== 32'h0005_000A || mem[1] !== 32'h0001_000B || mem[2] !== 32'h0003_000C) begin
      bad++; $display("FAIL rle_pkts: got %h %h %h want 0005000a 0001000b 0003000c",
                      mem[0], mem[1], mem[2]);
    end
  endtask

  task automatic test_saturate();
    int base;
    int base4;
    set_cfg(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 4'd0, 1'b1, 8'd1, 10'd0, 11'd1);
    do_start();
    base  = wr_cnt;
    base4 = q4.size();
    repeat (20) step(16'h0055);
    step(16'h0066);
    idle(2);
    total++;
    if (q4.size() - base4 !== 2) begin
      bad++; $display("FAIL sat_count: got %0d writes want 2", q4.size() - base4);
    end else begin
      total++;
      if (q4[base4] !== 20'hF_0055 || q4[base4+1] !== 20'h5_0055) begin
        bad++; $display("FAIL sat_pkts: got %h %h want f0055 50055", q4[base4], q4[base4+1]);
      end
    end
    total++;
    if (wr_cnt - base !== 1 || mem[0] !== 32'h0014_0055 || state !== 3'd2) begin
      bad++; $display("FAIL sat_wide: got writes=%0d pkt=%h state=%0d want 1/00140055/2",
                      wr_cnt - base, mem[0], state);
    end
    do_abort();
  endtask

  task automatic test_cfg_error_abort();
    int base;
    set_cfg(1'b1, 1'b0, 1'b0, 16'h0077, 16'hFFFF, 4'd0, 1'b1, 8'd1, 10'd1000, 11'd100);
    do_start();
    idle(2);
    total++;
    if (cfg_error !== 1'b1 || state !== 3'd0) begin
      bad++; $display("FAIL cfg_error: got err=%b state=%0d want 1/0", cfg_error, state);
    end
    cfg_post_count = 11'd24;
    do_start();
    total++;
    if (cfg_error !== 1'b0 || state !== 3'd1) begin
      bad++; $display("FAIL cfg_boundary: got err=%b state=%0d want 0/1", cfg_error, state);
    end
    do_abort();
    cfg_pre_count  = 10'd0;
    cfg_post_count = 11'd10;
    do_start();
    step(16'h0001);
    step(16'h0077);
    total++;
    if (state !== 3'd3) begin bad++; $display("FAIL abort_post_entry: got %0d want 3", state); end
    step(16'h0002);
    step(16'h0003);
    sample_in    = 16'h0004;
    sample_valid = 1'b1;
    abort        = 1'b1;
    tick();
    abort        = 1'b0;
    sample_valid = 1'b0;
    base = wr_cnt;
    total++;
    if (state !== 3'd0 || wr_en !== 1'b0) begin
      bad++; $display("FAIL abort_post: got state=%0d wr_en=%b want 0/0", state, wr_en);
    end
    step(16'h0005); step(16'h0006); step(16'h0007);
    idle(2);
    total++;
    if (wr_cnt - base !== 0) begin
      bad++; $display("FAIL abort_quiet: got %0d writes want 0", wr_cnt - base);
    end
  endtask

  task automatic test_async_reset();
    set_cfg(1'b1, 1'b0, 1'b0, 16'h0033, 16'hFFFF, 4'd0, 1'b1, 8'd1, 10'd0, 11'd10);
    do_start();
    step(16'h0001);
    step(16'h0002);
    step(16'h0033);
    step(16'h0005);
    total++;
    if (state !== 3'd3 || wr_en !== 1'b1 || trig_addr !== 10'd2) begin
      bad++; $display("FAIL rst_setup: got state=%0d wr_en=%b trig=%0d want 3/1/2", state, wr_en, trig_addr);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({state, wr_en, done, cfg_error} !== 6'b000000 ||
        {wr_addr, trig_addr, wr_data} !== 52'd0) begin
      bad++; $display("FAIL async_reset: got state=%0d wr_en=%b addr=%0d trig=%0d data=%h, want all 0",
                      state, wr_en, wr_addr, trig_addr, wr_data);
    end
    #3;
    reset_n = 1'b1;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_pattern_norle();
    test_back_to_back();
    test_edge();
    test_rle();
    test_saturate();
    test_cfg_error_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
